// File: rtl/leaky_relu_pipe.sv
// Multi-lane two-stage activation pipeline: pass / relu / leaky / leaky-derivative
// on LANES signed Q(FRAC) elements per beat, with valid/ready on both sides.
module leaky_relu_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       leak_factor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_DERIV = 2'b11
  } mode_e;

  // One extra bit over the full product keeps the rounding add from wrapping.
  localparam int PW     = 2*WIDTH + 1;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [PW-1:0] RND_W = (FRAC > 0) ? (PW'(1) << RND_SH) : '0;
  localparam logic signed [PW-1:0] ONE_W = PW'(1) << FRAC;
  localparam logic signed [PW-1:0] MAX_W = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_W = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  // Returns {sat_flag, value} clamped into the signed WIDTH range.
  function automatic logic [WIDTH:0] sat_fn(input logic signed [PW-1:0] v);
    logic [WIDTH:0] y;
    if (v > MAX_W)
      y = {1'b1, MAX_W[WIDTH-1:0]};
    else if (v < MIN_W)
      y = {1'b1, MIN_W[WIDTH-1:0]};
    else
      y = {1'b0, v[WIDTH-1:0]};
    return y;
  endfunction

  function automatic logic [WIDTH:0] lane_fn(
    input logic signed [WIDTH-1:0] x,
    input mode_e                   m,
    input logic signed [WIDTH-1:0] lk
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] le;
    logic signed [PW-1:0] scaled;
    logic                 pos;
    logic [WIDTH:0]       y;
    xe     = {{(PW-WIDTH){x[WIDTH-1]}}, x};
    le     = {{(PW-WIDTH){lk[WIDTH-1]}}, lk};
    pos    = !x[WIDTH-1] && (x != '0);
    scaled = (xe * le + RND_W) >>> FRAC;
    y      = '0;
    case (m)
      MODE_PASS:  y = {1'b0, x};
      MODE_RELU:  y = pos ? {1'b0, x} : '0;
      MODE_LEAKY: y = pos ? {1'b0, x} : sat_fn(scaled);
      MODE_DERIV: y = sat_fn(pos ? ONE_W : le);
      default:    y = '0;
    endcase
    return y;
  endfunction

  logic                   s1_valid;
  logic [LANES*WIDTH-1:0] s1_data;
  mode_e                  s1_mode;
  logic [WIDTH-1:0]       s1_leak;

  logic                   s2_valid;
  logic [LANES*WIDTH-1:0] s2_data;
  logic [LANES-1:0]       s2_sat;

  logic                   s1_adv;
  logic                   s2_adv;
  logic [LANES*WIDTH-1:0] res_data;
  logic [LANES-1:0]       res_sat;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst && s1_adv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s1_leak  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= mode_e'(mode);
        s1_leak <= leak_factor;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH:0] r;
    assign r                          = lane_fn(s1_data[g*WIDTH +: WIDTH], s1_mode, s1_leak);
    assign res_data[g*WIDTH +: WIDTH] = r[WIDTH-1:0];
    assign res_sat[g]                 = r[WIDTH];
  end

  // S2 only reloads when it drains, so a stalled output stays frozen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= res_data;
        s2_sat  <= res_sat;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_sat   = s2_sat;

endmodule

// File: tb/tb_leaky_relu_pipe.sv
// Scoreboard bench for leaky_relu_pipe: directed beats plus a randomized
// regression against an integer reference model.
module tb_leaky_relu_pipe;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  mode;
  logic [15:0] leak_factor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_sat;

  leaky_relu_pipe #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .mode        (mode),
    .leak_factor (leak_factor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sat;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rmode  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #(10_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: lane-wise integer arithmetic, floor((x*leak + half)/2^FRAC), clamped.
  function automatic void ref_beat(input logic [63:0] d, input logic [1:0] m,
                                   input logic [15:0] lk,
                                   output logic [63:0] y, output logic [3:0] s);
    longint x, l, p, q, r;
    y = '0;
    s = '0;
    l = longint'(signed'(lk));
    for (int i = 0; i < LANES; i++) begin
      x = longint'(signed'(d[i*16 +: 16]));
      r = x;
      case (m)
        2'd0: r = x;
        2'd1: r = (x > 0) ? x : 0;
        2'd2: begin
          if (x <= 0) begin
            p = x * l + 128;
            q = p / 256;
            if ((p % 256 != 0) && (p < 0)) q = q - 1;
            r = q;
          end
        end
        default: r = (x > 0) ? 256 : l;
      endcase
      if (r > 32767) begin
        r = 32767;
        s[i] = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        s[i] = 1'b1;
      end
      y[i*16 +: 16] = r[15:0];
    end
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    case ($urandom_range(0, 9))
      0: v = 16'h8000;
      1: v = 16'h7FFF;
      2: v = 16'h0000;
      3: v = 16'h0001;
      4: v = 16'hFFFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // out_ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low
  initial begin
    int ph;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = pat[ph];
          ph = (ph + 1) % 4;
        end
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops and compares on every output transfer; checks stall stability.
  initial begin
    bit          prev_stall;
    logic [63:0] prev_d;
    logic [3:0]  prev_s;
    exp_t        e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_s = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_data", out_data, prev_d);
          chk("stall_sat", 64'(out_sat), 64'(prev_s));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected no beat (cycle %0d)", out_data, cyc);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_sat", 64'(out_sat), 64'(e.sat));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(2));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_s = out_sat;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [63:0] d, input logic [1:0] m, input logic [15:0] lk,
                      input logic [63:0] ed, input logic [3:0] es, input bit lat);
    bit   done;
    int   n;
    exp_t e;
    in_data = d;
    mode = m;
    leak_factor = lk;
    in_valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      chk("in_ready", 64'(in_ready), 64'(rst && (out_ready || sb.size() < 2)));
      if (in_ready) begin
        e.data = ed;
        e.sat = es;
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n >= 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_out_sat", 64'(out_sat), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [63:0] d, ed;
    logic [3:0]  es;
    logic [1:0]  m;
    logic [15:0] lk;

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    mode = 2'b00;
    leak_factor = '0;
    rmode = 0;
    idle(3);
    do_reset();

    // single leaky beat with latency check
    send({16'h0001, 16'h0000, 16'hFF00, 16'h0300}, 2'b10, 16'h0033,
         {16'h0001, 16'h0000, 16'hFFCD, 16'h0300}, 4'b0000, 1'b1);
    drain();

    // saturation and near-saturation rounding
    send({16'h0000, 16'h0000, 16'hFFFF, 16'h8000}, 2'b10, 16'h7FFF,
         {16'h0000, 16'h0000, 16'hFF80, 16'h8000}, 4'b0001, 1'b1);
    drain();

    // four modes back-to-back
    d = {16'h7FFF, 16'h0000, 16'hFFFB, 16'h0005};
    send(d, 2'b00, 16'h0080, d, 4'b0000, 1'b1);
    send(d, 2'b01, 16'h0080, {16'h7FFF, 16'h0000, 16'h0000, 16'h0005}, 4'b0000, 1'b1);
    send(d, 2'b10, 16'h0080, {16'h7FFF, 16'h0000, 16'hFFFE, 16'h0005}, 4'b0000, 1'b1);
    send(d, 2'b11, 16'h0080, {16'h0100, 16'h0080, 16'h0080, 16'h0100}, 4'b0000, 1'b1);
    drain();

    // backpressure with out_ready 1,0,0,1
    rmode = 1;
    idle(1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < LANES; i++) d[i*16 +: 16] = 16'(k*4 + i + 1);
      send(d, 2'b00, 16'h0000, d, 4'b0000, 1'b0);
    end
    drain();

    // reset with two beats in flight
    rmode = 3;
    idle(2);
    send(64'h1111_2222_3333_4444, 2'b00, 16'h0000, 64'h1111_2222_3333_4444, 4'b0000, 1'b0);
    send(64'h5555_6666_7777_8888, 2'b00, 16'h0000, 64'h5555_6666_7777_8888, 4'b0000, 1'b0);
    rmode = 0;
    do_reset();
    idle(5);
    send({16'h0000, 16'hFFFF, 16'h0100, 16'h8000}, 2'b01, 16'h0000,
         {16'h0000, 16'h0000, 16'h0100, 16'h0000}, 4'b0000, 1'b1);
    drain();

    // random regression
    rmode = 2;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      for (int i = 0; i < LANES; i++) d[i*16 +: 16] = rand_val();
      m = 2'($urandom_range(0, 3));
      lk = rand_val();
      ref_beat(d, m, lk, ed, es);
      send(d, m, lk, ed, es, 1'b0);
    end
    rmode = 0;
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
